intercal_alu_seq: RTL and testbench

Parametrised, sequential successor to the single-cycle INTERCAL ALU: performs mingle (`$`), select (`~`), and the unary AND/OR/XOR operators on WIDTH-bit operands. Uses a start/busy/done handshake, so it can be driven by a microsequencer or by a byte-serial pin wrapper in the top-level TT tile. Select is bit-serial by default, with one bit per cycle, to save area. A fast combinational select can be compiled in instead.

---
 rtl/intercal_alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_intercal_alu_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/intercal_alu_seq.sv
// ============================================================================
// intercal_alu_seq
//   Sequential INTERCAL ALU: mingle ($), select (~) and the unary AND/OR/XOR
//   operators on WIDTH-bit operands, behind a start/busy/done handshake.
//
//   Build option:
//     INTERCAL_ALU_FAST_SELECT_EN  defined   -> select is a combinational
//                                              packing network, single-cycle
//                                              timing like the other ops.
//                                  undefined -> select is bit-serial, one
//                                              operand bit per cycle.
//
//   Ports:
//     i_clk     clock, all state changes on the rising edge
//     i_rst     synchronous active-high reset
//     i_start   request, accepted only while idle
//     i_op      000 mingle, 001 select, 010 AND, 011 OR, 100 XOR, else illegal
//     i_a/i_b   operands, latched on an accepted start
//     o_busy    high from the cycle after acceptance until the done cycle
//     o_done    one-cycle pulse, o_result/o_err valid in that cycle
//     o_result  registered result, held until the next accepted start
//     o_err     registered error flag, updated with o_result
// ============================================================================
module intercal_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_err
);

  localparam int HALF = WIDTH / 2;
  localparam int IW   = $clog2(WIDTH);

  localparam logic [2:0] OP_MINGLE = 3'b000;
  localparam logic [2:0] OP_SEL    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;

  // S_EXEC is the cycle in which the result register is loaded; S_FIN is the
  // cycle in which done is visible, so busy spans both.
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_EXEC, S_FIN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_oa;
  logic [WIDTH-1:0] r_ob;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic [WIDTH-1:0] w_mingle;
  logic             w_mingle_err;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_err;
  logic             w_alu_load;

`ifndef INTERCAL_ALU_FAST_SELECT_EN
  logic [IW-1:0]    r_idx;   // source bit being examined
  logic [IW-1:0]    r_ptr;   // next packed destination bit
`endif

  // Mingle interleaves the low halves: A on odd bits, B on even bits.
  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_mingle
      assign w_mingle[2*gi+1] = r_oa[gi];
      assign w_mingle[2*gi]   = r_ob[gi];
    end
  endgenerate

  assign w_mingle_err = (|r_oa[WIDTH-1:HALF]) | (|r_ob[WIDTH-1:HALF]);

  // Rotate right by one, so bit i pairs with bit (i+1) mod WIDTH.
  assign w_rot = {r_oa[0], r_oa[WIDTH-1:1]};

`ifdef INTERCAL_ALU_FAST_SELECT_EN
  // Priority packing: each set mask bit claims the next free result bit.
  function automatic logic [WIDTH-1:0] select_pack(
    input logic [WIDTH-1:0] val,
    input logic [WIDTH-1:0] mask
  );
    logic [WIDTH-1:0] res;
    logic [IW-1:0]    p;
    res = '0;
    p   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (mask[k]) begin
        res[p] = val[k];
        p      = p + 1'b1;
      end
    end
    return res;
  endfunction
`endif

  always_comb begin
    w_alu_result = '0;
    w_alu_err    = 1'b0;
    w_alu_load   = 1'b1;
    case (r_op)
      OP_MINGLE: begin
        w_alu_result = w_mingle;
        w_alu_err    = w_mingle_err;
      end
      OP_SEL: begin
`ifdef INTERCAL_ALU_FAST_SELECT_EN
        w_alu_result = select_pack(r_oa, r_ob);
`else
        // The serial path has already built the result in place.
        w_alu_load = 1'b0;
`endif
      end
      OP_AND:  w_alu_result = r_oa & w_rot;
      OP_OR:   w_alu_result = r_oa | w_rot;
      OP_XOR:  w_alu_result = r_oa ^ w_rot;
      default: w_alu_err    = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
`ifdef INTERCAL_ALU_FAST_SELECT_EN
          w_state_next = S_EXEC;
`else
          w_state_next = (i_op == OP_SEL) ? S_SEL : S_EXEC;
`endif
        end
      end
`ifndef INTERCAL_ALU_FAST_SELECT_EN
      S_SEL: begin
        if (r_idx == IW'(WIDTH - 1)) w_state_next = S_EXEC;
      end
`endif
      S_EXEC:  w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_oa     <= '0;
      r_ob     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
`ifndef INTERCAL_ALU_FAST_SELECT_EN
      r_idx    <= '0;
      r_ptr    <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op <= i_op;
            r_oa <= i_a;
            r_ob <= i_b;
            if (i_op == OP_SEL) r_result <= '0;
`ifndef INTERCAL_ALU_FAST_SELECT_EN
            r_idx <= '0;
            r_ptr <= '0;
`endif
          end
        end
`ifndef INTERCAL_ALU_FAST_SELECT_EN
        S_SEL: begin
          if (r_ob[r_idx]) begin
            r_result[r_ptr] <= r_oa[r_idx];
            r_ptr           <= r_ptr + 1'b1;
          end
          r_idx <= r_idx + 1'b1;
        end
`endif
        S_EXEC: begin
          if (w_alu_load) r_result <= w_alu_result;
          r_err <= w_alu_err;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_FIN);
  assign o_result = r_result;
  assign o_err    = r_err;

endmodule

// File: tb/tb_intercal_alu_seq.sv
module tb_intercal_alu_seq;

  localparam int WIDTH = 16;
`ifdef INTERCAL_ALU_FAST_SELECT_EN
  localparam int SEL_LAT = 1;
  localparam int RST_PRE = 0;
`else
  localparam int SEL_LAT = WIDTH + 1;
  localparam int RST_PRE = 4;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  intercal_alu_seq #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait (bounded) for done, compare against the scoreboard.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] xa,
                        input logic [WIDTH-1:0] xb, input logic [WIDTH-1:0] er,
                        input logic ee, input int el);
    exp_t e;
    int   lat;
    sb.push_back('{res: er, err: ee, lat: el});
    op = o; a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) tick();
      if (n == 1) tick();
      if (done) begin
        lat = n;
        break;
      end
    end
    e = sb.pop_front();
    $display("op=%0d a=%h b=%h -> result=%h err=%0d latency=%0d", o, xa, xb, result, err, lat);
    check({tag, "_lat"},    32'(lat),    32'(e.lat));
    check({tag, "_busy"},   32'(busy),   32'd1);
    check({tag, "_result"}, 32'(result), 32'(e.res));
    check({tag, "_err"},    32'(err),    32'(e.err));
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   ndone;
    logic [WIDTH-1:0] got_res;
    logic got_err;
    exp_t e;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_err",    32'(err),    32'd0);

    run_op("mingle0", 3'b000, 16'h00FF, 16'h0000, 16'hAAAA, 1'b0, 1);
    run_op("mingle1", 3'b000, 16'h0100, 16'h0003, 16'h0005, 1'b1, 1);
    run_op("select0", 3'b001, 16'h1234, 16'h00FF, 16'h0034, 1'b0, SEL_LAT);
    run_op("and0",    3'b010, 16'h8001, 16'h0000, 16'h8000, 1'b0, 1);
    run_op("xor0",    3'b100, 16'h0001, 16'h0000, 16'h8001, 1'b0, 1);
    run_op("or0",     3'b011, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1);
    run_op("or1",     3'b011, 16'h1234, 16'h0000, 16'h1B3E, 1'b0, 1);
    run_op("ill7",    3'b111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1);
    run_op("ill5",    3'b101, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1);
    run_op("sel_m0",  3'b001, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, SEL_LAT);
    run_op("sel_all", 3'b001, 16'hA5C3, 16'hFFFF, 16'hA5C3, 1'b0, SEL_LAT);

    // Start pulse during a running select must be ignored.
    sb.push_back('{res: 16'h00F0, err: 1'b0, lat: SEL_LAT});
    op = 3'b001; a = 16'hF0F0; b = 16'hFF00; start = 1'b1;
    tick();
    op = 3'b000; a = 16'hFFFF; b = 16'hFFFF;
    ndone = 0; got_res = '0; got_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      tick();
      start = 1'b0;
      if (done) begin
        ndone++;
        got_res = result;
        got_err = err;
      end
    end
    e = sb.pop_front();
    $display("select with ignored start: dones=%0d result=%h err=%0d", ndone, got_res, got_err);
    check("ign_ndone",  32'(ndone),   32'd1);
    check("ign_result", 32'(got_res), 32'(e.res));
    check("ign_err",    32'(got_err), 32'(e.err));

    // Reset in the middle of a select aborts it.
    op = 3'b001; a = 16'h1234; b = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int n = 0; n < RST_PRE; n++) begin
      tick();
      if (done) ndone++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_err",    32'(err),    32'd0);
    for (int n = 0; n < 25; n++) begin
      tick();
      if (done) ndone++;
    end
    $display("select aborted by reset: dones=%0d result=%h", ndone, result);
    check("abort_ndone", 32'(ndone), 32'd0);
    run_op("mingle_after", 3'b000, 16'h00FF, 16'h00FF, 16'hFFFF, 1'b0, 1);

    // Reset coinciding with a start drops the start.
    rst = 1'b1; start = 1'b1; op = 3'b010; a = 16'h8001;
    tick();
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    check("rst_start_busy", 32'(busy), 32'd0);
    for (int n = 0; n < 5; n++) begin
      tick();
      if (done) ndone++;
    end
    $display("reset overlapping start: dones=%0d busy=%0d", ndone, busy);
    check("rst_start_ndone", 32'(ndone), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
